input_conditioner: RTL and testbench
====================================

# input_conditioner

Synchronises and debounces the three raw slide-switch inputs (H, DC, C) before they reach the Moore alarm FSM. Each channel passes through a metastability synchroniser and a per-channel debounce state machine. The block produces clean levels plus single-cycle rise and fall strobes. It sits between the board switches and the Moore stage, and its `clean` bus drives the Moore inputs directly.

## Interface
- `N`, 3: number of channels. Bit 0 = H, bit 1 = DC, bit 2 = C.
- `SYNC_STAGES`, 2: synchroniser depth, ≥ 2.
- `DB_CYCLES`, 16: consecutive stable samples required to accept a new level, ≥ 2. Counter width is `$clog2(DB_CYCLES)`.

- `CLK`, in, 1: design clock; all flops update on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `raw`, in, N: unsynchronised switch levels.
- `clean`, out, N: debounced levels.
- `rise`, out, N: one-cycle strobe when `clean[i]` goes 0→1.
- `fall`, out, N: one-cycle strobe when `clean[i]` goes 1→0.
- `changed`, out, 1: OR of all `rise` and `fall` bits.

## Operation
- **Synchroniser:** `s[i]` is `raw[i]` delayed through `SYNC_STAGES` flops. No logic is placed between the synchroniser flops.
- **Per-channel FSM:** states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO, each with counter `cnt`.
  - STABLE_LO, `s=1`: go to WAIT_HI, `cnt←1`. With `s=0`: hold.
  - WAIT_HI, `s=1`:
    - if `cnt==DB_CYCLES-1`: go to STABLE_HI, `clean←1`, `rise←1`, `cnt←0`;
    - otherwise `cnt←cnt+1`.
  - WAIT_HI, `s=0`: return to STABLE_LO, `cnt←0`. `clean` is unchanged and no strobe is issued.
  - STABLE_HI and WAIT_LO mirror the above with polarity inverted, producing `fall`.
- **Output registers:** `clean`, `rise` and `fall` are registered. `changed` is combinational from the registered `rise` and `fall`.
- **Strobe width:** `rise` and `fall` are high for exactly one cycle. For a given channel, they are never high at the same time.
- **Channel independence:** channels are fully independent. Simultaneous transitions on several channels give simultaneous strobes.
- **Counter range:** `cnt` never exceeds `DB_CYCLES-1`, so there is no wrap-around.
- **Async reset:** asserting `reset` (low) immediately clears every synchroniser flop, state (to STABLE_LO), `cnt`, `clean`, `rise` and `fall`. This also applies mid-debounce, and any in-progress count is discarded.
- **Switch high at reset release:** if a switch is already high when reset is released, it is treated as a normal 0→1 transition. `clean` rises after the full latency, together with a `rise` strobe.

## Timing
- **Reset values:** `clean=0`, `rise=0`, `fall=0`, `changed=0`.
- **Latency:** let edge k be the first edge that samples a new level on `raw[i]`.
  - `clean[i]` and the strobe update on edge k+SYNC_STAGES+DB_CYCLES-1.
  - With default parameters this is edge k+17.
- **Bounce rejection:** a new level shorter than `DB_CYCLES` consecutive samples at `s` produces no change and no strobe.
- **Bounce restart:** a single-sample reversal during WAIT restarts the count. The next accepted transition therefore requires a further `DB_CYCLES` consecutive samples.
- **Strobe timing:** a strobe is asserted in the same cycle `clean` changes and deasserts on the next edge.
- **Downstream timing:** the Moore stage sees new `clean` values one cycle after the strobe edge, exactly as for any registered input.

## Test plan
- **Reset with switches high:** hold `reset=0` with `raw=3'b111`, then release.
  - All outputs stay 0 through edge k+16.
  - At edge k+17, `clean=3'b111` and `rise=3'b111` for one cycle, with `changed=1`.
- **Bounce rejection:** with `raw[0]` stable low, pulse it high for 10 cycles then low.
  - `clean[0]`, `rise[0]` and `changed` stay 0 throughout.
- **Bounce during WAIT_HI:** drive `raw[1]` high 12 cycles, low 1 cycle, then high.
  - `clean[1]` rises exactly 17 edges after the final rising sample, not earlier.
  - `rise[1]` pulses exactly once.
- **Falling transition:** from `clean[2]=1`, drop `raw[2]` to 0 and hold.
  - At edge k+17, `clean[2]=0` and `fall[2]=1` for one cycle.
  - `rise[2]` stays 0.
- **Reset mid-debounce:** assert `reset` 8 cycles into WAIT_HI.
  - All outputs are 0 immediately.
  - After release with `raw` still high, `clean` rises at the full 17-edge latency.
- **Simultaneous channels:** toggle `raw[0]` up and `raw[2]` down on the same edge.
  - `rise[0]` and `fall[2]` assert on the same cycle.
  - `changed` is high for exactly one cycle.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner: switch synchroniser and debouncer.
// Produces clean levels plus one-cycle rise/fall strobes.
module input_conditioner #(
  parameter int N           = 3,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic [N-1:0] raw,
  output logic [N-1:0] clean,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         changed
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } db_state_t;

  logic [N-1:0]  sync_q [SYNC_STAGES];
  logic [N-1:0]  s;

  db_state_t     state_q [N];
  db_state_t     state_d [N];
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];

  logic [N-1:0]  clean_d;
  logic [N-1:0]  rise_d;
  logic [N-1:0]  fall_d;

  // Plain flop chain; nothing between the stages.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        sync_q[k] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int k = 1; k < SYNC_STAGES; k++)
        sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce state, counters and output registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= STABLE_LO;
        cnt_q[i]   <= '0;
      end
      clean <= '0;
      rise  <= '0;
      fall  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      clean <= clean_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

  // Per-channel next state; a reversal in WAIT
  // drops back to the stable state and restarts.
  always_comb begin
    clean_d = clean;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        STABLE_LO: begin
          if (s[i]) begin
            state_d[i] = WAIT_HI;
            cnt_d[i]   = CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (!s[i]) begin
            state_d[i] = STABLE_LO;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = STABLE_HI;
            cnt_d[i]   = '0;
            clean_d[i] = 1'b1;
            rise_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s[i]) begin
            state_d[i] = WAIT_LO;
            cnt_d[i]   = CNT_ONE;
          end
        end
        WAIT_LO: begin
          if (s[i]) begin
            state_d[i] = STABLE_HI;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = STABLE_LO;
            cnt_d[i]   = '0;
            clean_d[i] = 1'b0;
            fall_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = STABLE_LO;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  assign changed = |{rise, fall};

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed and random checks
// against a sliding-window debounce model.
module tb_input_conditioner;

  localparam int N  = 3;
  localparam int S  = 2;
  localparam int DB = 16;

  logic         CLK;
  logic         reset;
  logic [N-1:0] raw;
  logic [N-1:0] clean;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic         changed;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] rh [$];
  logic [N-1:0] fs [$];
  logic [N-1:0] m_clean = '0;
  logic [N-1:0] m_rise  = '0;
  logic [N-1:0] m_fall  = '0;

  input_conditioner #(
    .N(N), .SYNC_STAGES(S), .DB_CYCLES(DB)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .raw(raw),
    .clean(clean),
    .rise(rise),
    .fall(fall),
    .changed(changed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  // Level flips once the last DB synchronised
  // samples all disagree with the current level.
  task automatic model_step(input logic [N-1:0] r);
    int sz;
    logic [N-1:0] sv;
    bit all;
    rh.push_back(r);
    sz = rh.size();
    sv = (sz > S) ? rh[sz-1-S] : '0;
    fs.push_back(sv);
    m_rise = '0;
    m_fall = '0;
    sz = fs.size();
    if (sz >= DB) begin
      for (int i = 0; i < N; i++) begin
        all = 1'b1;
        for (int j = 0; j < DB; j++)
          if (fs[sz-1-j][i] == m_clean[i])
            all = 1'b0;
        if (all) begin
          if (m_clean[i]) m_fall[i] = 1'b1;
          else            m_rise[i] = 1'b1;
          m_clean[i] = ~m_clean[i];
        end
      end
    end
  endtask

  task automatic cyc(input logic [N-1:0] r);
    @(negedge CLK);
    raw = r;
    @(posedge CLK);
    model_step(r);
    #1;
    chk("clean", 32'(clean), 32'(m_clean));
    chk("rise", 32'(rise), 32'(m_rise));
    chk("fall", 32'(fall), 32'(m_fall));
    chk("changed", 32'(changed),
        32'(|{m_rise, m_fall}));
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    @(negedge CLK);
    #2;
    reset = 1'b0;
    raw = r;
    #1;
    chk("rst_clean", 32'(clean), 0);
    chk("rst_rise", 32'(rise), 0);
    chk("rst_fall", 32'(fall), 0);
    chk("rst_changed", 32'(changed), 0);
    rh.delete();
    fs.delete();
    m_clean = '0;
    m_rise  = '0;
    m_fall  = '0;
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #2;
    reset = 1'b1;
  endtask

  initial begin : stim
    int n_r, n_c, at, n_b;
    logic [N-1:0] r;
    int hold;
    reset = 1'b0;
    raw = 3'b111;

    do_reset(3'b111);
    for (int j = 1; j <= 20; j++) begin
      cyc(3'b111);
      if (j == 17) chk("t1_pre", 32'(clean), 0);
      if (j == 18) begin
        chk("t1_clean", 32'(clean), 32'h7);
        chk("t1_rise", 32'(rise), 32'h7);
        chk("t1_chg", 32'(changed), 1);
      end
      if (j == 19) chk("t1_rise_off", 32'(rise), 0);
    end

    repeat (20) cyc(3'b110);
    n_r = 0;
    n_c = 0;
    repeat (10) begin
      cyc(3'b111);
      n_r += int'(rise[0]);
      n_c += int'(changed);
    end
    repeat (25) begin
      cyc(3'b110);
      n_r += int'(rise[0]) + int'(clean[0]);
      n_c += int'(changed);
    end
    chk("bounce_rise0", 32'(n_r), 0);
    chk("bounce_chg", 32'(n_c), 0);

    repeat (20) cyc(3'b100);
    n_r = 0;
    at = 0;
    repeat (12) begin
      cyc(3'b110);
      n_r += int'(rise[1]);
    end
    cyc(3'b100);
    n_r += int'(rise[1]);
    for (int j = 1; j <= 30; j++) begin
      cyc(3'b110);
      if (rise[1]) begin
        n_r++;
        at = j;
      end
    end
    chk("dc_rise_cnt", 32'(n_r), 1);
    chk("dc_rise_at", 32'(at), 18);

    n_r = 0;
    at = 0;
    for (int j = 1; j <= 25; j++) begin
      cyc(3'b010);
      n_r += int'(rise[2]);
      if (fall[2]) at = j;
    end
    chk("c_fall_at", 32'(at), 18);
    chk("c_no_rise", 32'(n_r), 0);
    chk("c_clean", 32'(clean[2]), 0);

    repeat (20) cyc(3'b110);
    n_c = 0;
    n_b = 0;
    repeat (20) begin
      cyc(3'b011);
      n_c += int'(changed);
      if (rise == 3'b001 && fall == 3'b100)
        n_b++;
    end
    chk("sim_chg", 32'(n_c), 1);
    chk("sim_both", 32'(n_b), 1);

    repeat (8) cyc(3'b111);
    do_reset(3'b111);
    for (int j = 1; j <= 20; j++) begin
      cyc(3'b111);
      if (j == 17) chk("mr_pre", 32'(clean), 0);
      if (j == 18) begin
        chk("mr_clean", 32'(clean), 32'h7);
        chk("mr_rise", 32'(rise), 32'h7);
      end
    end

    r = 3'b000;
    repeat (60) begin
      if ($urandom_range(0, 3) == 0)
        hold = $urandom_range(18, 30);
      else
        hold = $urandom_range(1, 20);
      r = r ^ N'($urandom_range(1, 7));
      repeat (hold) cyc(r);
    end
    repeat (25) cyc(r);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
